// File: rtl/fb_pkg.sv
// Shared constants and types for the frame-buffer write arbiter.
// Optional feature macro: FB_WR_ADDR_CHECK_EN (see fb_write_arbiter).
package fb_pkg;

  localparam int NUM_REQ  = 4;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 16;
  localparam int FB_DEPTH = 24000;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  // Pointer width for a requester index; never below one bit.
  function automatic int fb_ptr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int PTR_W = fb_ptr_w(NUM_REQ);

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Requester handshake plus frame-buffer write port, bundled for the arbiter.
// master = arbiter side, slave = requesters / buffer side.
interface fb_write_arbiter_if #(
  parameter int NUM_REQ = fb_pkg::NUM_REQ,
  parameter int ADDR_W  = fb_pkg::ADDR_W,
  parameter int DATA_W  = fb_pkg::DATA_W
) ();

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic                      load;
  logic [DATA_W-1:0]         out;
  logic [ADDR_W-1:0]         address;

  modport master (
    input  req, req_addr, req_data,
    output ack, load, out, address
  );

  modport slave (
    output req, req_addr, req_data,
    input  ack, load, out, address
  );

endinterface

// File: rtl/fb_rr_pick.sv
// Combinational round-robin picker: first set req bit after last_grant, wrapping.
module fb_rr_pick #(
  parameter int NUM_REQ = fb_pkg::NUM_REQ,
  parameter int PTR_W   = fb_pkg::PTR_W
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   last_grant,
  output logic [PTR_W-1:0]   winner,
  output logic               any_req
);

  int               idx;
  logic [PTR_W-1:0] idx_p;

  // Scan from farthest to nearest so the candidate closest to last_grant+1 wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    winner  = '0;
    any_req = |req;
    idx     = 0;
    idx_p   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_p = PTR_W'(idx);
      if (req[idx_p]) winner = idx_p;
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter for the single frame-buffer write port; one write per two cycles.
// Define FB_WR_ADDR_CHECK_EN to drop (but still ack) writes at or beyond FB_DEPTH.
module fb_write_arbiter #(
  parameter int NUM_REQ  = fb_pkg::NUM_REQ,
  parameter int ADDR_W   = fb_pkg::ADDR_W,
  parameter int DATA_W   = fb_pkg::DATA_W,
  parameter int FB_DEPTH = fb_pkg::FB_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  fb_write_arbiter_if.master   bus,
  output logic                 busy,
  output logic                 addr_err
);

  import fb_pkg::*;

  localparam int               PW        = fb_ptr_w(NUM_REQ);
  localparam logic [PW-1:0]    LAST_INIT = PW'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [PW-1:0]        last_grant_q;
  logic [PW-1:0]        winner;
  logic                 any_req;
  logic                 grant;
  logic                 issue;
  logic                 in_range;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [ADDR_W-1:0]    win_addr;
  logic [DATA_W-1:0]    win_data;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 load_q;
  logic [DATA_W-1:0]    out_q;
  logic [ADDR_W-1:0]    addr_q;

  fb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PW)
  ) u_pick (
    .req        (bus.req),
    .last_grant (last_grant_q),
    .winner     (winner),
    .any_req    (any_req)
  );

  // Constant-index mux keeps the winner's addr/data selection width-clean.
  always_comb begin
    win_onehot = '0;
    win_addr   = '0;
    win_data   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == PW'(i)) begin
        win_onehot[i] = 1'b1;
        win_addr      = bus.req_addr[i*ADDR_W +: ADDR_W];
        win_data      = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: a grant always takes exactly one WRITE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: requests are only considered in IDLE.
  always_comb begin
    busy  = (state_q == WRITE);
    grant = (state_q == IDLE) && any_req;
    issue = grant && in_range;
  end

`ifdef FB_WR_ADDR_CHECK_EN
  logic err_q;

  assign in_range = 32'(win_addr) < 32'(FB_DEPTH);

  always_ff @(posedge clk) begin
    if (reset)                  err_q <= 1'b0;
    else if (grant && !in_range) err_q <= 1'b1;
  end

  assign addr_err = err_q;
`else
  assign in_range = 1'b1;
  assign addr_err = 1'b0;
`endif

  // Grant registers: ack/pointer follow every grant, the buffer port only issued writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: out/address are reset as well since their value is visible on the buffer port.
      ack_q        <= '0;
      load_q       <= 1'b0;
      out_q        <= '0;
      addr_q       <= '0;
      last_grant_q <= LAST_INIT;
    end else begin
      ack_q  <= grant ? win_onehot : '0;
      load_q <= issue;
      if (grant) last_grant_q <= winner;
      if (issue) begin
        out_q  <= win_data;
        addr_q <= win_addr;
      end
    end
  end

  assign bus.ack     = ack_q;
  assign bus.load    = load_q;
  assign bus.out     = out_q;
  assign bus.address = addr_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: directed vector table, then random traffic vs a model.
// Expectations adapt when FB_WR_ADDR_CHECK_EN is defined.
module tb_fb_write_arbiter;

  localparam int N     = 4;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 24000;
`ifdef FB_WR_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic addr_err;

  always #5 clk = ~clk;

  fb_write_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  fb_write_arbiter #(
    .NUM_REQ  (N),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .FB_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .addr_err (addr_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  typedef struct {
    bit                 rst;
    logic [N-1:0]       req;
    logic [N*AW-1:0]    addrs;
    logic [N*DW-1:0]    datas;
    logic [N-1:0]       ack;
    bit                 load;
    logic [AW-1:0]      addr;
    logic [DW-1:0]      out;
    bit                 busy;
    bit                 err;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit rst, input logic [N-1:0] req,
                              input logic [N*AW-1:0] addrs, input logic [N*DW-1:0] datas,
                              input logic [N-1:0] ack, input bit load,
                              input logic [AW-1:0] addr, input logic [DW-1:0] out,
                              input bit bsy, input bit err);
    vec_t v;
    v.rst = rst; v.req = req; v.addrs = addrs; v.datas = datas;
    v.ack = ack; v.load = load; v.addr = addr; v.out = out; v.busy = bsy; v.err = err;
    tbl.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_outputs(input string tag, input logic [N-1:0] ack, input bit load,
                             input logic [AW-1:0] addr, input logic [DW-1:0] out,
                             input bit bsy, input bit err);
    check({tag, " ack"},      bus.ack,     ack);
    check({tag, " load"},     bus.load,    load);
    check({tag, " address"},  bus.address, addr);
    check({tag, " out"},      bus.out,     out);
    check({tag, " busy"},     busy,        bsy);
    check({tag, " addr_err"}, addr_err,    err);
  endtask

  // ---------------- behavioural model for the random phase ----------------
  logic [N-1:0]  r_req;
  logic [AW-1:0] r_addr [N];
  logic [DW-1:0] r_data [N];
  int            wait_cnt [N];

  logic [N-1:0]  m_ack;
  bit            m_load;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_out;
  bit            m_busy;
  bit            m_err;
  int            m_lg;

  task automatic apply_random(input bit r);
    reset = r;
    for (int i = 0; i < N; i++) begin
      bus.req[i]                  = r_req[i];
      bus.req_addr[i*AW +: AW]    = r_addr[i];
      bus.req_data[i*DW +: DW]    = r_data[i];
    end
  endtask

  // One grant per two cycles; a pending requester sees at most N-1 other grants first.
  task automatic model_step(input bit r);
    int w;
    if (r) begin
      m_ack = '0; m_load = 0; m_addr = '0; m_out = '0; m_busy = 0; m_err = 0; m_lg = N - 1;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else if (m_busy) begin
      m_ack = '0; m_load = 0; m_busy = 0;
    end else if (r_req != '0) begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_lg + k) % N;
        if (w < 0 && r_req[c]) w = c;
      end
      check($sformatf("fairness req%0d", w), 64'(wait_cnt[w] <= N - 1), 64'd1);
      for (int i = 0; i < N; i++) if (i != w && r_req[i]) wait_cnt[i]++;
      wait_cnt[w] = 0;
      m_ack  = N'(1) << w;
      m_lg   = w;
      m_busy = 1;
      if (CHK && r_addr[w] >= AW'(DEPTH)) begin
        m_load = 0;
        m_err  = 1;
      end else begin
        m_load = 1;
        m_addr = r_addr[w];
        m_out  = r_data[w];
      end
    end else begin
      m_ack = '0; m_load = 0;
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return ($urandom % 2 == 0) ? AW'($urandom_range(23990, 24010)) : AW'($urandom_range(0, 65535));
  endfunction

  initial begin
    logic [N*AW-1:0] ra, sa, oa, ba;
    logic [N*DW-1:0] rd, sd, od, bd;
    logic [N-1:0] dummy;

    ra = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    rd = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    sa = {16'h0000, 16'h0123, 16'h0000, 16'h0000};
    sd = {16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
    oa = {16'h1003, 16'h1002, 16'd24000, 16'h1000};
    od = {16'hA003, 16'hA002, 16'h1234, 16'hA000};
    ba = {16'h1003, 16'h1002, 16'd23999, 16'h1000};
    bd = {16'hA003, 16'hA002, 16'h5555, 16'hA000};

    // Reset for two cycles, then ten quiet cycles.
    add(1, 4'b0000, ra, rd, 4'b0000, 0, 16'h0, 16'h0, 0, 0);
    add(1, 4'b0000, ra, rd, 4'b0000, 0, 16'h0, 16'h0, 0, 0);
    for (int i = 0; i < 10; i++)
      add(0, 4'b0000, ra, rd, 4'b0000, 0, 16'h0, 16'h0, 0, 0);
    // Single write from requester 2.
    add(0, 4'b0100, sa, sd, 4'b0100, 1, 16'h0123, 16'hFFFF, 1, 0);
    add(0, 4'b0000, sa, sd, 4'b0000, 0, 16'h0123, 16'hFFFF, 0, 0);
    // Fresh reset, then all four held: 0,1,2,3,0,1 every other cycle.
    add(1, 4'b0000, ra, rd, 4'b0000, 0, 16'h0,    16'h0,    0, 0);
    add(0, 4'b1111, ra, rd, 4'b0001, 1, 16'h1000, 16'hA000, 1, 0);
    add(0, 4'b1111, ra, rd, 4'b0000, 0, 16'h1000, 16'hA000, 0, 0);
    add(0, 4'b1111, ra, rd, 4'b0010, 1, 16'h1001, 16'hA001, 1, 0);
    add(0, 4'b1111, ra, rd, 4'b0000, 0, 16'h1001, 16'hA001, 0, 0);
    add(0, 4'b1111, ra, rd, 4'b0100, 1, 16'h1002, 16'hA002, 1, 0);
    add(0, 4'b1111, ra, rd, 4'b0000, 0, 16'h1002, 16'hA002, 0, 0);
    add(0, 4'b1111, ra, rd, 4'b1000, 1, 16'h1003, 16'hA003, 1, 0);
    add(0, 4'b1111, ra, rd, 4'b0000, 0, 16'h1003, 16'hA003, 0, 0);
    add(0, 4'b1111, ra, rd, 4'b0001, 1, 16'h1000, 16'hA000, 1, 0);
    add(0, 4'b1111, ra, rd, 4'b0000, 0, 16'h1000, 16'hA000, 0, 0);
    add(0, 4'b1111, ra, rd, 4'b0010, 1, 16'h1001, 16'hA001, 1, 0);
    // last_grant=1: requests during WRITE ignored, then 0011 -> 0, then 0010 -> 1.
    add(0, 4'b0011, ra, rd, 4'b0000, 0, 16'h1001, 16'hA001, 0, 0);
    add(0, 4'b0011, ra, rd, 4'b0001, 1, 16'h1000, 16'hA000, 1, 0);
    add(0, 4'b0010, ra, rd, 4'b0000, 0, 16'h1000, 16'hA000, 0, 0);
    add(0, 4'b0010, ra, rd, 4'b0010, 1, 16'h1001, 16'hA001, 1, 0);
    add(0, 4'b0000, ra, rd, 4'b0000, 0, 16'h1001, 16'hA001, 0, 0);
    // Reset during WRITE, then requester 0 is granted exactly once.
    add(0, 4'b0100, ra, rd, 4'b0100, 1, 16'h1002, 16'hA002, 1, 0);
    add(1, 4'b0100, ra, rd, 4'b0000, 0, 16'h0,    16'h0,    0, 0);
    add(0, 4'b0001, ra, rd, 4'b0001, 1, 16'h1000, 16'hA000, 1, 0);
    add(0, 4'b0000, ra, rd, 4'b0000, 0, 16'h1000, 16'hA000, 0, 0);
    add(0, 4'b0000, ra, rd, 4'b0000, 0, 16'h1000, 16'hA000, 0, 0);
    // Depth boundary: 24000 is dropped only with the range check built in; 23999 always issues.
    add(0, 4'b0010, oa, od, 4'b0010, !CHK, CHK ? 16'h1000 : 16'd24000,
        CHK ? 16'hA000 : 16'h1234, 1, CHK);
    add(0, 4'b0000, oa, od, 4'b0000, 0, CHK ? 16'h1000 : 16'd24000,
        CHK ? 16'hA000 : 16'h1234, 0, CHK);
    add(0, 4'b0010, ba, bd, 4'b0010, 1, 16'd23999, 16'h5555, 1, CHK);
    add(0, 4'b0000, ba, bd, 4'b0000, 0, 16'd23999, 16'h5555, 0, CHK);

    foreach (tbl[k]) begin
      reset        = tbl[k].rst;
      bus.req      = tbl[k].req;
      bus.req_addr = tbl[k].addrs;
      bus.req_data = tbl[k].datas;
      tick();
      cmp_outputs($sformatf("row%0d", k), tbl[k].ack, tbl[k].load, tbl[k].addr,
                  tbl[k].out, tbl[k].busy, tbl[k].err);
    end

    // ---------------- random traffic against the model ----------------
    r_req = '0;
    for (int i = 0; i < N; i++) begin
      r_addr[i] = '0; r_data[i] = '0; wait_cnt[i] = 0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bit r;
      r = (cyc == 0) || ($urandom_range(0, 199) == 0);
      apply_random(r);
      model_step(r);
      tick();
      cmp_outputs($sformatf("rand%0d", cyc), m_ack, m_load, m_addr, m_out, m_busy, m_err);
      check($sformatf("rand%0d ack_onehot", cyc), 64'($countones(bus.ack) <= 1), 64'd1);
      check($sformatf("rand%0d load_implies_ack", cyc), 64'(!bus.load || (bus.ack != '0)), 64'd1);
      dummy = bus.ack;
      for (int i = 0; i < N; i++) begin
        if (dummy[i]) begin
          if ($urandom % 2 == 0) r_req[i] = 1'b0;
          else begin
            r_addr[i] = rand_addr();
            r_data[i] = DW'($urandom);
          end
        end else if (!r_req[i] && ($urandom % 3 == 0)) begin
          r_req[i]    = 1'b1;
          r_addr[i]   = rand_addr();
          r_data[i]   = DW'($urandom);
          wait_cnt[i] = 0;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
